// File: rtl/vidas_ctrl.sv
// Lives manager for the HUD: counts lives, runs the post-hit invulnerability
// window with a ship blink flag, and flags game over when lives run out.
module vidas_ctrl #(
    parameter int MAX_LIVES    = 7,
    parameter int START_LIVES  = 3,
    parameter int INV_FRAMES   = 120,
    parameter int BLINK_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       hit,
    input  logic       bonus,
    input  logic       frame_tick,
    output logic [2:0] vidas,
    output logic       game_over,
    output logic       invuln,
    output logic       blink,
    output logic       hit_ack
);

    localparam int INV_W = $clog2(INV_FRAMES + 1);
    localparam int BLK_W = $clog2(BLINK_FRAMES + 1);

    localparam logic [2:0]       MAX_V    = 3'(MAX_LIVES);
    localparam logic [2:0]       START_V  = 3'(START_LIVES);
    localparam logic [INV_W-1:0] INV_LAST = INV_W'(INV_FRAMES - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        INV  = 2'd2,
        OVER = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             hit_q;
    logic             hit_rise;
    logic [INV_W-1:0] inv_cnt;
    logic [INV_W-1:0] inv_cnt_nxt;
    logic [BLK_W-1:0] blk_cnt;
    logic [BLK_W-1:0] blk_cnt_nxt;
    logic [2:0]       vidas_nxt;
    logic             blink_nxt;
    logic             hit_ack_nxt;
    logic             game_over_nxt;
    logic             invuln_nxt;

    // Bonus lives saturate at the ceiling instead of wrapping the 3-bit count.
    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v >= MAX_V) ? MAX_V : v + 3'd1;
    endfunction

    assign hit_rise = hit & ~hit_q;

    always_comb begin
        state_nxt   = state;
        vidas_nxt   = vidas;
        inv_cnt_nxt = inv_cnt;
        blk_cnt_nxt = blk_cnt;
        blink_nxt   = blink;
        hit_ack_nxt = 1'b0;

        if (start) begin
            state_nxt   = PLAY;
            vidas_nxt   = START_V;
            inv_cnt_nxt = '0;
            blk_cnt_nxt = '0;
            blink_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                end
                PLAY: begin
                    if (hit_rise) begin
                        hit_ack_nxt = 1'b1;
                        // A simultaneous bonus cancels the hit's decrement,
                        // which also rescues the last life from game over.
                        if (!bonus && vidas == 3'd1) begin
                            state_nxt = OVER;
                            vidas_nxt = 3'd0;
                        end else begin
                            state_nxt   = INV;
                            vidas_nxt   = bonus ? vidas : vidas - 3'd1;
                            inv_cnt_nxt = '0;
                            blk_cnt_nxt = '0;
                            blink_nxt   = 1'b1;
                        end
                    end else if (bonus) begin
                        vidas_nxt = sat_inc(vidas);
                    end
                end
                INV: begin
                    if (bonus) begin
                        vidas_nxt = sat_inc(vidas);
                    end
                    if (frame_tick) begin
                        if (inv_cnt == INV_LAST) begin
                            state_nxt   = PLAY;
                            blink_nxt   = 1'b0;
                            inv_cnt_nxt = '0;
                            blk_cnt_nxt = '0;
                        end else begin
                            inv_cnt_nxt = inv_cnt + INV_W'(1);
                            if (blk_cnt == BLK_LAST) begin
                                blink_nxt   = ~blink;
                                blk_cnt_nxt = '0;
                            end else begin
                                blk_cnt_nxt = blk_cnt + BLK_W'(1);
                            end
                        end
                    end
                end
                OVER: begin
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        game_over_nxt = (state_nxt == OVER);
        invuln_nxt    = (state_nxt == INV);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hit_q     <= 1'b0;
            inv_cnt   <= '0;
            blk_cnt   <= '0;
            vidas     <= 3'd0;
            blink     <= 1'b0;
            hit_ack   <= 1'b0;
            game_over <= 1'b0;
            invuln    <= 1'b0;
        end else begin
            state     <= state_nxt;
            hit_q     <= hit;
            inv_cnt   <= inv_cnt_nxt;
            blk_cnt   <= blk_cnt_nxt;
            vidas     <= vidas_nxt;
            blink     <= blink_nxt;
            hit_ack   <= hit_ack_nxt;
            game_over <= game_over_nxt;
            invuln    <= invuln_nxt;
        end
    end

endmodule

// File: tb/tb_vidas_ctrl.sv
// Scoreboard bench for vidas_ctrl: directed stimulus pushes expected output
// snapshots and expected hit acknowledgements; a negedge monitor compares them.
module tb_vidas_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       hit = 1'b0;
    logic       bonus = 1'b0;
    logic       frame_tick = 1'b0;
    logic [2:0] vidas;
    logic       game_over;
    logic       invuln;
    logic       blink;
    logic       hit_ack;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] vidas;
        logic       go;
        logic       inv;
        logic       blk;
        logic       ack;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] ack_q[$];

    vidas_ctrl #(
        .MAX_LIVES(7), .START_LIVES(3), .INV_FRAMES(120), .BLINK_FRAMES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hit(hit), .bonus(bonus),
        .frame_tick(frame_tick), .vidas(vidas), .game_over(game_over),
        .invuln(invuln), .blink(blink), .hit_ack(hit_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Single monitor process: snapshot comparisons plus hit_ack accounting.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("vidas", 32'(vidas), 32'(e.vidas));
            chk("game_over", 32'(game_over), 32'(e.go));
            chk("invuln", 32'(invuln), 32'(e.inv));
            chk("blink", 32'(blink), 32'(e.blk));
            chk("hit_ack", 32'(hit_ack), 32'(e.ack));
        end
        if (hit_ack === 1'b1) begin
            if (ack_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_hit_ack: got 1, expected 0 (t=%0t)", $time);
            end else begin
                chk("ack_vidas", 32'(vidas), 32'(ack_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_o(input logic [2:0] v, input logic g, input logic i,
                            input logic b, input logic a);
        exp_t e;
        e = '{vidas: v, go: g, inv: i, blk: b, ack: a};
        exp_q.push_back(e);
    endtask

    // Hold frame_tick for a full 120-tick window; blink starts at 1 and flips every 8 ticks.
    task automatic run_inv(input logic [2:0] v);
        frame_tick = 1'b1;
        for (int k = 1; k <= 120; k++) begin
            step();
            if (k == 120) expect_o(v, 1'b0, 1'b0, 1'b0, 1'b0);
            else          expect_o(v, 1'b0, 1'b1, ((k / 8) % 2 == 0), 1'b0);
        end
        frame_tick = 1'b0;
    endtask

    task automatic hit_edge(input logic [2:0] ack_v, input logic accepted);
        if (accepted) ack_q.push_back(ack_v);
        hit = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset state, then start
        step(); step();
        expect_o(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        expect_o(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b1; step(); start = 1'b0;
        expect_o(3'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // 2: hit held 50 cycles gives a single accepted hit
        hit_edge(3'd2, 1'b1);
        expect_o(3'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (49) step();
        expect_o(3'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        hit = 1'b0; step();

        // 3: fresh edge ignored in INV, then full blink window
        hit_edge(3'd0, 1'b0);
        expect_o(3'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        hit = 1'b0; step();
        run_inv(3'd2);

        // 4: down to zero lives, OVER ignores hit and bonus, start recovers
        hit_edge(3'd1, 1'b1);
        expect_o(3'd1, 1'b0, 1'b1, 1'b1, 1'b1);
        hit = 1'b0;
        run_inv(3'd1);
        hit_edge(3'd0, 1'b1);
        expect_o(3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        hit = 1'b0; step();
        bonus = 1'b1; step(); bonus = 1'b0;
        expect_o(3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        hit_edge(3'd0, 1'b0);
        expect_o(3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        hit = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        expect_o(3'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // 5: bonus saturates at 7; hit+bonus on the last life saves the player
        bonus = 1'b1;
        for (int n = 4; n <= 8; n++) begin
            step();
            expect_o((n > 7) ? 3'd7 : 3'(n), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        bonus = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        expect_o(3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        hit_edge(3'd2, 1'b1);
        expect_o(3'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        hit = 1'b0;
        run_inv(3'd2);
        hit_edge(3'd1, 1'b1);
        expect_o(3'd1, 1'b0, 1'b1, 1'b1, 1'b1);
        hit = 1'b0;
        run_inv(3'd1);
        bonus = 1'b1;
        hit_edge(3'd1, 1'b1);
        expect_o(3'd1, 1'b0, 1'b1, 1'b1, 1'b1);
        hit = 1'b0; bonus = 1'b0; step();
        bonus = 1'b1; step(); bonus = 1'b0;
        expect_o(3'd2, 1'b0, 1'b1, 1'b1, 1'b0);

        // 6: async reset mid-INV, then start beats hit and bonus
        frame_tick = 1'b1; repeat (3) step(); frame_tick = 1'b0;
        #2 rst_n = 1'b0;
        expect_o(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        start = 1'b1; hit = 1'b1; bonus = 1'b1;
        step();
        start = 1'b0; bonus = 1'b0;
        expect_o(3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        expect_o(3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        hit = 1'b0; step();

        // A tick on the cycle of entering INV is not counted in the window
        frame_tick = 1'b1;
        hit_edge(3'd2, 1'b1);
        expect_o(3'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        hit = 1'b0; frame_tick = 1'b0;
        run_inv(3'd2);

        step(); step();
        chk("ack_queue_left", 32'(ack_q.size()), 32'd0);
        chk("exp_queue_left", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
